// File: rtl/flash_read_buffer.sv
// Four-entry direct-mapped read buffer in front of an APB flash port.
// Cacheable reads hit locally; everything else is forwarded as one APB transfer.
module flash_read_buffer #(
  parameter logic [31:0] FLASH_START = 32'h4000_0000,
  parameter logic [31:0] FLASH_END   = 32'h47FF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        flush,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [2:0] {StIdle, StLookup, StSetup, StAccess, StResp} state_e;

  state_e      r_state, w_state_d;
  logic [31:2] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_flush_seen;
  logic [3:0]  r_valid;
  logic [27:0] r_tag  [4];
  logic [31:0] r_data [4];

  logic [31:0] w_word_addr;
  logic [1:0]  w_idx;
  logic        w_cacheable, w_hit, w_accept, w_done, w_fill, w_in_flight;
  logic        w_unused_addr;

  assign w_unused_addr = ^req_addr[1:0];
  assign w_word_addr   = {r_addr, 2'b00};
  assign w_idx         = r_addr[3:2];
  // Range check uses the word-aligned address only.
  assign w_cacheable   = !r_write && (w_word_addr >= FLASH_START) && (w_word_addr <= FLASH_END);
  assign w_hit         = w_cacheable && r_valid[w_idx] && (r_tag[w_idx] == r_addr[31:4]);
  assign w_accept      = req_valid && req_ready;
  assign w_done        = (r_state == StAccess) && pready;
  assign w_fill        = w_done && w_cacheable && !pslverr && !r_flush_seen;
  assign w_in_flight   = (r_state == StLookup) || (r_state == StSetup) || (r_state == StAccess);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = StLookup;
      StLookup: w_state_d = w_hit ? StResp : StSetup;
      StSetup:  w_state_d = StAccess;
      StAccess: if (pready) w_state_d = StResp;
      StResp:   if (resp_ready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_flush_seen <= 1'b0;
      r_valid      <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_addr       <= req_addr[31:2];
        r_write      <= req_write;
        r_wdata      <= req_write ? req_wdata : 32'h0;
        r_wstrb      <= req_write ? req_wstrb : 4'h0;
        r_flush_seen <= 1'b0;
      end else if (flush && w_in_flight) begin
        r_flush_seen <= 1'b1;
      end
      if ((r_state == StLookup) && w_hit) begin
        r_rdata <= r_data[w_idx];
        r_err   <= 1'b0;
      end
      if (w_done) begin
        r_rdata <= prdata;
        r_err   <= pslverr;
      end
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_tag[w_idx]   <= r_addr[31:4];
        r_data[w_idx]  <= prdata;
      end
      if (w_done && r_write) r_valid <= '0;
      // Later assignment: flush beats a coincident fill.
      if (flush) r_valid <= '0;
    end
  end

  assign req_ready  = rst_n && (r_state == StIdle);
  assign resp_valid = (r_state == StResp);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign psel       = (r_state == StSetup) || (r_state == StAccess);
  assign penable    = (r_state == StAccess);
  assign paddr      = w_word_addr;
  assign pwrite     = r_write;
  assign pwdata     = r_wdata;
  assign pwstrb     = r_wstrb;

endmodule

// File: tb/tb_flash_read_buffer.sv
// Scenario bench for flash_read_buffer with a wait-state APB slave model and
// a response scoreboard queue.
module tb_flash_read_buffer;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        flush;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pwstrb;

  flash_read_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .flush(flush),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pwstrb(pwstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];

  // APB slave: fixed number of wait states per transfer, logs each setup phase.
  int unsigned slv_wait = 0;
  int unsigned wcnt = 0;
  logic [31:0] slv_data = 32'h0;
  logic        slv_err = 1'b0;
  int unsigned apb_xfers = 0;
  logic [31:0] last_paddr = 32'h0;
  logic [31:0] last_pwdata = 32'h0;
  logic        last_pwrite = 1'b0;
  logic [3:0]  last_pwstrb = 4'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pready <= 1'b0;
      wcnt   <= 0;
    end else if (psel && !penable) begin
      pready      <= (slv_wait == 0);
      wcnt        <= slv_wait;
      apb_xfers   <= apb_xfers + 1;
      last_paddr  <= paddr;
      last_pwdata <= pwdata;
      last_pwrite <= pwrite;
      last_pwstrb <= pwstrb;
    end else if (psel && penable && !pready) begin
      if (wcnt <= 1) pready <= 1'b1;
      wcnt <= wcnt - 1;
    end else begin
      pready <= 1'b0;
    end
  end

  assign prdata  = pready ? slv_data : 32'h0;
  assign pslverr = pready & slv_err;

  // Drives one request from IDLE, waits for the response and completes the handshake.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input int unsigned nwait,
                       input logic [31:0] sdata, input logic serr,
                       output logic [31:0] rd, output logic er, output int lat);
    slv_wait = nwait; slv_data = sdata; slv_err = serr;
    req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    if (!resp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: addr %h got resp_valid=0 want 1 within 200 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, psel, penable, pwrite, pwstrb, resp_rdata, paddr,
         pwdata} !== 106'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b re=%b ps=%b pe=%b pw=%b st=%h rd=%h pa=%h wd=%h want all 0",
               req_ready, resp_valid, resp_err, psel, penable, pwrite, pwstrb, resp_rdata,
               paddr, pwdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, psel, resp_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: rdy/psel/rv=%b want 100", {req_ready, psel, resp_valid});
    end
  endtask

  task automatic test_miss_hit();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    a0 = apb_xfers;
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    issue(32'h4000_0104, 1'b0, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er} !== e) begin n_bad++;
      $display("FAIL miss_data: got %h/%b want %h/%b", rd, er, e[32:1], e[0]); end
    n_cmp++; if (apb_xfers - a0 !== 1) begin n_bad++;
      $display("FAIL miss_xfers: got %0d want 1", apb_xfers - a0); end
    n_cmp++; if (lat !== 7) begin n_bad++;
      $display("FAIL miss_latency: got %0d want 7", lat); end
    n_cmp++; if (last_paddr !== 32'h4000_0104) begin n_bad++;
      $display("FAIL miss_paddr: got %h want 40000104", last_paddr); end
    a0 = apb_xfers;
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    issue(32'h4000_0106, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er} !== e) begin n_bad++;
      $display("FAIL hit_data: got %h/%b want %h/%b", rd, er, e[32:1], e[0]); end
    n_cmp++; if (lat !== 2) begin n_bad++;
      $display("FAIL hit_latency: got %0d want 2", lat); end
    n_cmp++; if (apb_xfers - a0 !== 0) begin n_bad++;
      $display("FAIL hit_xfers: got %0d want 0", apb_xfers - a0); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    logic [31:0] addrs [3];
    addrs[0] = 32'h4000_0104; addrs[1] = 32'h4000_0114; addrs[2] = 32'h4000_0104;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    a0 = apb_xfers;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({addrs[i] ^ 32'h5A00_0000 ^ i, 1'b0});
      issue(addrs[i], 1'b0, 32'h0, 4'h0, 1, addrs[i] ^ 32'h5A00_0000 ^ i, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++; if ({rd, er} !== e) begin n_bad++;
        $display("FAIL conflict_data%0d: got %h/%b want %h/%b", i, rd, er, e[32:1], e[0]); end
    end
    n_cmp++; if (apb_xfers - a0 !== 3) begin n_bad++;
      $display("FAIL conflict_xfers: got %0d want 3", apb_xfers - a0); end
  endtask

  task automatic test_uncached_write();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    a0 = apb_xfers;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({32'hC0DE_0000 + i, 1'b0});
      issue(32'h1000_0002, 1'b0, 32'h0, 4'h0, 0, 32'hC0DE_0000 + i, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++; if ({rd, er} !== e) begin n_bad++;
        $display("FAIL uncached_data%0d: got %h/%b want %h/%b", i, rd, er, e[32:1], e[0]); end
    end
    n_cmp++; if ({apb_xfers - a0, last_paddr, last_pwdata, last_pwstrb} !== {32'd2, 32'h1000_0000, 32'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL uncached_apb: xfers=%0d paddr=%h pwdata=%h pwstrb=%h want 2/10000000/0/0",
               apb_xfers - a0, last_paddr, last_pwdata, last_pwstrb); end
    exp_q.push_back({32'h0000_0000, 1'b0});
    issue(32'h1000_0018, 1'b1, 32'h1, 4'hF, 0, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er} !== e) begin n_bad++;
      $display("FAIL write_resp: got %h/%b want %h/%b", rd, er, e[32:1], e[0]); end
    n_cmp++; if ({last_pwrite, last_pwdata, last_pwstrb, last_paddr} !== {1'b1, 32'h1, 4'hF, 32'h1000_0018}) begin
      n_bad++;
      $display("FAIL write_apb: pwrite=%b pwdata=%h pwstrb=%h paddr=%h want 1/1/f/10000018",
               last_pwrite, last_pwdata, last_pwstrb, last_paddr); end
    a0 = apb_xfers;
    exp_q.push_back({32'h7777_0104, 1'b0});
    issue(32'h4000_0104, 1'b0, 32'h0, 4'h0, 0, 32'h7777_0104, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er, apb_xfers - a0} !== {e, 32'd1}) begin n_bad++;
      $display("FAIL write_invalidate: got %h/%b xfers=%0d want %h/%b xfers=1",
               rd, er, apb_xfers - a0, e[32:1], e[0]); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    logic [31:0] addrs [3];
    int unsigned want [3];
    addrs[0] = 32'h47FF_FFFE; want[0] = 1;
    addrs[1] = 32'h4800_0000; want[1] = 2;
    addrs[2] = 32'h3FFF_FFFC; want[2] = 2;
    for (int i = 0; i < 3; i++) begin
      a0 = apb_xfers;
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back({32'hB0B0_0000 + i, 1'b0});
        issue(addrs[i], 1'b0, 32'h0, 4'h0, 0, 32'hB0B0_0000 + i, 1'b0, rd, er, lat);
        e = exp_q.pop_front();
        n_cmp++; if ({rd, er} !== e) begin n_bad++;
          $display("FAIL boundary_data%0d_%0d: got %h/%b want %h/%b", i, k, rd, er, e[32:1], e[0]); end
        slv_data = 32'hFFFF_FFFF;
      end
      n_cmp++; if (apb_xfers - a0 !== want[i]) begin n_bad++;
        $display("FAIL boundary_xfers%0d: addr %h got %0d want %0d", i, addrs[i],
                 apb_xfers - a0, want[i]); end
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    exp_q.push_back({32'h0000_0BAD, 1'b1});
    issue(32'h4000_0200, 1'b0, 32'h0, 4'h0, 1, 32'h0000_0BAD, 1'b1, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er} !== e) begin n_bad++;
      $display("FAIL error_resp: got %h/%b want %h/%b", rd, er, e[32:1], e[0]); end
    a0 = apb_xfers;
    exp_q.push_back({32'h600D_0200, 1'b0});
    issue(32'h4000_0200, 1'b0, 32'h0, 4'h0, 0, 32'h600D_0200, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er, apb_xfers - a0} !== {e, 32'd1}) begin n_bad++;
      $display("FAIL error_nofill: got %h/%b xfers=%0d want %h/%b xfers=1",
               rd, er, apb_xfers - a0, e[32:1], e[0]); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    exp_q.push_back({32'hF1F1_0300, 1'b0});
    fork
      issue(32'h4000_0300, 1'b0, 32'h0, 4'h0, 3, 32'hF1F1_0300, 1'b0, rd, er, lat);
      begin
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++;
          $display("FAIL flush_phase: psel/penable=%b want 11", {psel, penable}); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
    join
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er} !== e) begin n_bad++;
      $display("FAIL flush_data: got %h/%b want %h/%b", rd, er, e[32:1], e[0]); end
    for (int k = 0; k < 2; k++) begin
      a0 = apb_xfers;
      exp_q.push_back({32'hF2F2_0300, 1'b0});
      issue(32'h4000_0300, 1'b0, 32'h0, 4'h0, 0, k == 0 ? 32'hF2F2_0300 : 32'h0, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++; if ({rd, er, apb_xfers - a0} !== {e, (k == 0) ? 32'd1 : 32'd0}) begin n_bad++;
        $display("FAIL flush_reread%0d: got %h/%b xfers=%0d want %h/%b xfers=%0d", k, rd, er,
                 apb_xfers - a0, e[32:1], e[0], (k == 0) ? 1 : 0); end
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] rd; logic er; int lat; int unsigned a0; logic [32:0] e;
    int n;
    resp_ready = 1'b0;
    slv_wait = 0; slv_data = 32'hCAFE_F00D; slv_err = 1'b0;
    exp_q.push_back({32'hCAFE_F00D, 1'b0});
    req_addr = 32'h4000_0400; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({resp_valid, resp_rdata, resp_err, req_ready} !== {1'b1, e, 1'b0}) begin n_bad++;
        $display("FAIL backpressure%0d: rv=%b rd=%h re=%b rdy=%b want 1/%h/%b/0", i,
                 resp_valid, resp_rdata, resp_err, req_ready, e[32:1], e[0]); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_bad++;
      $display("FAIL backpressure_release: rv/rdy=%b want 01", {resp_valid, req_ready}); end
    slv_wait = 5; slv_data = 32'h5555_0500;
    req_addr = 32'h4000_0500; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++;
      $display("FAIL reset_pre: psel/penable=%b want 11", {psel, penable}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({psel, resp_valid} !== 2'b00) begin n_bad++;
      $display("FAIL reset_abort: psel/rv=%b want 00", {psel, resp_valid}); end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_bad++;
      $display("FAIL reset_noresp: rv/rdy=%b want 01", {resp_valid, req_ready}); end
    a0 = apb_xfers;
    exp_q.push_back({32'h6666_0500, 1'b0});
    issue(32'h4000_0500, 1'b0, 32'h0, 4'h0, 0, 32'h6666_0500, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++; if ({rd, er, apb_xfers - a0} !== {e, 32'd1}) begin n_bad++;
      $display("FAIL reset_nofill: got %h/%b xfers=%0d want %h/%b xfers=1",
               rd, er, apb_xfers - a0, e[32:1], e[0]); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;
    req_wdata = 32'h0; req_wstrb = 4'h0; resp_ready = 1'b1; flush = 1'b0;
    test_reset();
    test_miss_hit();
    test_conflict();
    test_uncached_write();
    test_boundary();
    test_error();
    test_flush();
    test_backpressure_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
